// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the
// extended synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // True ceiling log2 for any positive integer.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem_sdp.sv
// fifo_mem_sdp: simple dual-port RAM, one write port,
// one registered read port with read enable (read-first).
module fifo_mem_sdp #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; returns old data on a same-address write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_sync_ext.sv
// fifo_sync_ext: single-clock FIFO with any-integer depth,
// thresholds, flush, sticky error flags and optional FWFT.
module fifo_sync_ext
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       wr,
    input  logic [WIDTH-1:0]           data,
    input  logic                       rd,
    output logic [WIDTH-1:0]           q,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [clog2(DEPTH+1)-1:0]  usedw,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = clog2(DEPTH + 1);
    localparam int AW = clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             ov;
    logic             rd_acc;
    logic             wr_acc;
    logic             mem_nz;
    logic             ram_re;
    logic             byp_load;
    logic             adv_rd;
    logic [WIDTH-1:0] ram_q;
    logic [WIDTH-1:0] byp_q;
    logic             byp_sel;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign full  = (usedw == CW'(DEPTH));
    assign empty = (FWFT == FIFO_FWFT) ? !ov : (usedw == '0);

    assign almost_full  = (int'(usedw) >= AF_LEVEL);
    assign almost_empty = (int'(usedw) <= AE_LEVEL);

    assign rd_acc = rd & !empty & !clr;
    assign wr_acc = wr & (!full | rd_acc) & !clr;

    // Words still in the RAM beyond the FWFT output register.
    assign mem_nz = (usedw > {{(CW-1){1'b0}}, ov});

    // Read-side control: direct reads, or FWFT prefetch/bypass.
    always_comb begin
        ram_re   = 1'b0;
        byp_load = 1'b0;
        adv_rd   = 1'b0;
        if (FWFT == FIFO_FWFT) begin
            if (!clr && (!ov || rd_acc)) begin
                if (mem_nz) begin
                    ram_re = 1'b1;
                    adv_rd = 1'b1;
                end else if (wr_acc) begin
                    byp_load = 1'b1;
                    adv_rd   = 1'b1;
                end
            end
        end else begin
            ram_re = rd_acc;
            adv_rd = rd_acc;
        end
    end

    // Pointers, occupancy, output-valid and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            usedw     <= '0;
            ov        <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            usedw     <= '0;
            ov        <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (adv_rd) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_acc, rd_acc})
                2'b10:   usedw <= usedw + 1'b1;
                2'b01:   usedw <= usedw - 1'b1;
                default: usedw <= usedw;
            endcase
            if (ram_re || byp_load) begin
                ov <= 1'b1;
            end else if (rd_acc) begin
                ov <= 1'b0;
            end
            if (wr && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // FWFT bypass: a write into an empty FIFO lands directly on q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_q   <= '0;
            byp_sel <= 1'b0;
        end else if (byp_load) begin
            byp_q   <= data;
            byp_sel <= 1'b1;
        end else if (ram_re) begin
            byp_sel <= 1'b0;
        end
    end

    assign q = byp_sel ? byp_q : ram_q;

    fifo_mem_sdp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (data),
        .re    (ram_re),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_fifo_sync_ext.sv
// tb_fifo_sync_ext: three FIFO configurations driven by shared
// stimulus, checked against a list-based reference model.
module tb_fifo_sync_ext;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] data = 8'h00;

    logic [7:0] a_q, b_q, c_q;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic       c_full, c_empty, c_af, c_ae, c_ovf, c_udf;
    logic [2:0] a_usedw;
    logic [3:0] b_usedw;
    logic [4:0] c_usedw;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fifo_sync_ext #(.WIDTH(8), .DEPTH(5), .FWFT(0),
                    .AF_LEVEL(3), .AE_LEVEL(2)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .data(data),
        .rd(rd), .q(a_q), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .usedw(a_usedw),
        .overflow(a_ovf), .underflow(a_udf));

    fifo_sync_ext #(.WIDTH(8), .DEPTH(8), .FWFT(1),
                    .AF_LEVEL(6), .AE_LEVEL(2)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .data(data),
        .rd(rd), .q(b_q), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .usedw(b_usedw),
        .overflow(b_ovf), .underflow(b_udf));

    fifo_sync_ext #(.WIDTH(8), .DEPTH(16), .FWFT(0),
                    .AF_LEVEL(14), .AE_LEVEL(2)) u_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .data(data),
        .rd(rd), .q(c_q), .full(c_full), .empty(c_empty),
        .almost_full(c_af), .almost_empty(c_ae), .usedw(c_usedw),
        .overflow(c_ovf), .underflow(c_udf));

    // Reference model: each FIFO is an ordered list of words.
    int         m_dep [3] = '{5, 8, 16};
    int         m_fw  [3] = '{0, 1, 0};
    int         m_af  [3] = '{3, 6, 14};
    int         m_ae  [3] = '{2, 2, 2};
    logic [7:0] ms    [3][16];
    int         msz   [3];
    logic [7:0] mq    [3];
    logic       movf  [3];
    logic       mudf  [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            msz[k]  = 0;
            mq[k]   = 8'h00;
            movf[k] = 1'b0;
            mudf[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        int   sz;
        logic racc, wacc;
        sz = msz[k];
        if (clr) begin
            msz[k]  = 0;
            movf[k] = 1'b0;
            mudf[k] = 1'b0;
            return;
        end
        racc = rd && (sz > 0);
        wacc = wr && ((sz < m_dep[k]) || racc);
        if (rd && sz == 0) mudf[k] = 1'b1;
        if (wr && !wacc) movf[k] = 1'b1;
        if (racc) begin
            if (m_fw[k] == 0) mq[k] = ms[k][0];
            for (int i = 0; i < 15; i++) ms[k][i] = ms[k][i+1];
            sz--;
        end
        if (wacc) begin
            ms[k][sz] = data;
            sz++;
        end
        if (m_fw[k] == 1 && sz > 0) mq[k] = ms[k][0];
        msz[k] = sz;
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h",
                     nm, got, exp);
        end
    endtask

    task automatic chk_inst(input int k, input string nm,
                            input int u, input logic f, input logic e,
                            input logic af, input logic ae,
                            input int qv, input logic ov,
                            input logic un);
        chk({nm, ".usedw"}, u, msz[k]);
        chk({nm, ".full"}, int'(f), int'(msz[k] == m_dep[k]));
        chk({nm, ".empty"}, int'(e), int'(msz[k] == 0));
        chk({nm, ".almost_full"}, int'(af), int'(msz[k] >= m_af[k]));
        chk({nm, ".almost_empty"}, int'(ae), int'(msz[k] <= m_ae[k]));
        chk({nm, ".q"}, qv, int'(mq[k]));
        chk({nm, ".overflow"}, int'(ov), int'(movf[k]));
        chk({nm, ".underflow"}, int'(un), int'(mudf[k]));
    endtask

    task automatic check_all();
        chk_inst(0, "A", int'(a_usedw), a_full, a_empty, a_af, a_ae,
                 int'(a_q), a_ovf, a_udf);
        chk_inst(1, "B", int'(b_usedw), b_full, b_empty, b_af, b_ae,
                 int'(b_q), b_ovf, b_udf);
        chk_inst(2, "C", int'(c_usedw), c_full, c_empty, c_af, c_ae,
                 int'(c_q), c_ovf, c_udf);
    endtask

    // Drive one cycle, advance the model on the edge, check after it.
    task automatic step(input logic c, input logic w, input logic r,
                        input logic [7:0] d);
        clr  = c;
        wr   = w;
        rd   = r;
        data = d;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        check_all();
    endtask

    typedef struct {
        logic       c;
        logic       w;
        logic       r;
        logic [7:0] d;
        int         u;
        logic       f;
        logic       e;
        logic [7:0] q;
        logic       ov;
    } vec_t;

    vec_t tv [12];

    initial begin
        // Directed table for the DEPTH=5 standard FIFO.
        tv[0]  = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 8'h00, 1'b0};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 8'h00, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 8'h33, 3, 1'b0, 1'b0, 8'h00, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 8'h44, 4, 1'b0, 1'b0, 8'h00, 1'b0};
        tv[4]  = '{1'b0, 1'b1, 1'b0, 8'h55, 5, 1'b1, 1'b0, 8'h00, 1'b0};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 8'h66, 5, 1'b1, 1'b0, 8'h00, 1'b1};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 4, 1'b0, 1'b0, 8'h11, 1'b1};
        tv[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 3, 1'b0, 1'b0, 8'h22, 1'b1};
        tv[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b0, 8'h33, 1'b1};
        tv[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 8'h44, 1'b1};
        tv[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 8'h55, 1'b1};
        tv[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 8'h55, 1'b0};

        model_reset();
        #2;
        check_all();
        chk("reset.A.empty", int'(a_empty), 1);
        chk("reset.B.almost_empty", int'(b_ae), 1);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(tv[i].c, tv[i].w, tv[i].r, tv[i].d);
            chk($sformatf("tv%0d.usedw", i), int'(a_usedw), tv[i].u);
            chk($sformatf("tv%0d.full", i), int'(a_full), int'(tv[i].f));
            chk($sformatf("tv%0d.empty", i), int'(a_empty), int'(tv[i].e));
            chk($sformatf("tv%0d.q", i), int'(a_q), int'(tv[i].q));
            chk($sformatf("tv%0d.ovf", i), int'(a_ovf), int'(tv[i].ov));
        end

        // Full FIFO with simultaneous read and write, pointer wrap.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b0, 8'(i * 17));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'(8'h66 + i * 17));
            chk("rw_full.q", int'(a_q), (i + 1) * 17);
            chk("rw_full.usedw", int'(a_usedw), 5);
            chk("rw_full.full", int'(a_full), 1);
            chk("rw_full.ovf", int'(a_ovf), 0);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk("wrap.q", int'(a_q), (i + 4) * 17);
        end
        chk("wrap.empty", int'(a_empty), 1);

        // FWFT: a single write shows on q without any read.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'hA5);
        chk("fwft.empty", int'(b_empty), 0);
        chk("fwft.q", int'(b_q), 8'hA5);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("fwft.ack_empty", int'(b_empty), 1);
        chk("fwft.ack_usedw", int'(b_usedw), 0);

        // Threshold flags on the DEPTH=16 FIFO.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int n = 1; n <= 16; n++) begin
            step(1'b0, 1'b1, 1'b0, 8'(n));
            chk($sformatf("thr%0d.ae", n), int'(c_ae), int'(n <= 2));
            chk($sformatf("thr%0d.af", n), int'(c_af), int'(n >= 14));
            chk($sformatf("thr%0d.full", n), int'(c_full), int'(n == 16));
        end

        // Read+write on empty: write lands, underflow flagged, clr.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h3C);
        chk("rw_empty.udf", int'(a_udf), 1);
        chk("rw_empty.usedw", int'(a_usedw), 1);
        chk("rw_empty.B.udf", int'(b_udf), 1);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("clr.usedw", int'(a_usedw), 0);
        chk("clr.empty", int'(a_empty), 1);
        chk("clr.udf", int'(a_udf), 0);

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
        chk("pre_rst.B.usedw", int'(b_usedw), 4);
        clr = 1'b0; wr = 1'b0; rd = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst.B.q", int'(b_q), 0);
        chk("rst.B.empty", int'(b_empty), 1);
        #1 rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0, 8'h77);
        chk("post_rst.B.q", int'(b_q), 8'h77);
        chk("post_rst.B.empty", int'(b_empty), 0);

        // Randomised traffic with varying fill bias.
        for (int i = 0; i < 3000; i++) begin
            int wp;
            logic c;
            wp = ((i / 300) % 2 == 1) ? 75 : 30;
            c  = ($urandom_range(0, 99) < 2);
            step(c, $urandom_range(0, 99) < wp,
                 $urandom_range(0, 99) < (100 - wp),
                 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync_ext.md
Name: fifo_sync_ext

Overview:
Parametrised single-clock FIFO, successor to the team's basic synchronous FIFO. Adds any-integer depth (not only 2^n), a correct full-range occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It is the general-purpose buffer between same-clock producer/consumer blocks.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, storage capacity in words (any integer >=2)
FWFT, 0, 0 = standard read (data one cycle after rd); 1 = first-word-fall-through
AF_LEVEL, DEPTH-2, almost_full asserted when usedw >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserted when usedw <= AE_LEVEL

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
clr  in  1  synchronous flush, active-high
wr  in  1  write request
data  in  WIDTH  write data
rd  in  1  read request (standard) / read acknowledge (FWFT)
q  out  WIDTH  read data
full  out  1  DEPTH words held
empty  out  1  no word readable
almost_full  out  1  usedw >= AF_LEVEL
almost_empty  out  1  usedw <= AE_LEVEL
usedw  out  CW  words held, CW = clog2(DEPTH+1); range 0..DEPTH inclusive
overflow  out  1  sticky: write attempted while full and not accepted
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n low, async): pointers, usedw, q, overflow, underflow = 0; empty=1, full=0, almost_empty=1, almost_full=0.
- Pointers: range 0..DEPTH-1; explicit wrap to 0 after DEPTH-1 (no power-of-2 masking). Occupancy held in a dedicated counter; full = (usedw==DEPTH), empty derived from counter (FWFT: see below).
- Accept rules: rd_acc = rd & !empty. wr_acc = wr & (!full | rd_acc) — write into a full FIFO is accepted when a read is accepted the same cycle.
- usedw: +1 on wr_acc only, -1 on rd_acc only, unchanged on both/neither. Never exceeds DEPTH, never below 0.
- Simultaneous rd+wr on empty: write accepted, read rejected, underflow set.
- Standard mode (FWFT=0): q updates on the edge after rd_acc with the head word; holds value otherwise. Write-to-readable latency: empty deasserts cycle after write edge.
- FWFT mode (FWFT=1): head word presented on q whenever empty=0; rd acknowledges and advances; next word visible on q the cycle after the ack edge. Internal output register counted in usedw. Write into empty FIFO: q valid and empty=0 one cycle after write edge (no rd required). q holds last value when empty.
- Error flags: overflow set on wr & !wr_acc; underflow set on rd & empty. Both sticky until clr or reset.
- clr: next edge resets pointers, usedw, overflow, underflow, FWFT output-valid to 0; q holds. clr dominates wr/rd in that cycle (nothing accepted, no error flags set).
- Thresholds compared against registered usedw; flags registered-equivalent (combinational from usedw register, glitch-free).
- Memory contents not reset.

Decomposition:
- Package fifo_pkg: clog2 function (true ceiling, valid for any integer), mode constants FIFO_STD=0, FIFO_FWFT=1.
- One sub-module fifo_mem_sdp: simple dual-port RAM, WIDTH x DEPTH, one write port, one registered read port with read enable; top level owns pointers, counter, flags, FWFT prefetch.

Test Plan:
- DEPTH=5, FWFT=0: write 0x11..0x55 -> full=1, usedw=5; 6th write -> rejected, overflow=1; 5 reads -> q=0x11..0x55 one cycle after each rd, empty=1.
- DEPTH=5: fill, then wr=rd=1 with data 0x66 -> q=0x11, usedw stays 5, full stays 1, overflow stays 0; pointer wraps 4->0 correctly over 3 full cycles.
- FWFT=1, DEPTH=8: single write 0xA5 -> next cycle empty=0, q=0xA5 with no rd; rd -> next cycle empty=1, usedw=0.
- DEPTH=16, AF_LEVEL=14, AE_LEVEL=2: writes one at a time -> almost_empty drops at usedw=3, almost_full rises at usedw=14, full at 16.
- Empty FIFO, rd=1 and wr=1 with 0x3C -> write accepted, underflow=1, usedw=1; clr pulse -> usedw=0, empty=1, underflow=0.
- Reset asserted mid-stream (usedw=4, FWFT=1) -> immediately usedw=0, empty=1, q=0, flags cleared; subsequent write of 0x77 appears on q one cycle later.
